// File: rtl/cl_pkg.sv
// Shared control-logic definitions: sequencer states, phases, SD geometry and
// default card addresses used by the content loader and the control-logic top.
package cl_pkg;

    typedef enum logic [2:0] {
        WAIT_READY = 3'd0,
        ISSUE      = 3'd1,
        READ       = 3'd2,
        SECTOR_END = 3'd3,
        WAIT_SONG  = 3'd4,
        DONE       = 3'd5
    } seq_state_t;

    typedef enum logic {
        PHASE_DATA = 1'b0,
        PHASE_SONG = 1'b1
    } phase_t;

    localparam int SECTOR_BYTES = 512;
    localparam int WORD_BYTES   = 4;

    localparam logic [31:0] DATA_ADR_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] SONG_ADR_DEFAULT = 32'h0001_0000;

endpackage

// File: rtl/sd_byte_packer.sv
// Turns sd_controller byte events into big-endian 32-bit words with a running
// word index and a one-cycle write strobe for the active phase.
module sd_byte_packer
    import cl_pkg::*;
(
    input  logic        clk25,
    input  logic        reset,
    input  logic        enable,
    input  logic        clear_cnt,
    input  logic        clear_index,
    input  logic        song_phase,
    input  logic        byte_available,
    input  logic [7:0]  din,
    output logic [31:0] word_out,
    output logic [15:0] word_index,
    output logic        data_write_en,
    output logic        song_write_en,
    output logic        sector_done
);

    localparam int CNT_W  = $clog2(SECTOR_BYTES);
    localparam int SLOT_W = $clog2(WORD_BYTES);

    logic             avail_q;
    logic [CNT_W-1:0] byte_cnt;
    logic [23:0]      partial;
    logic             word_valid;
    logic             capture;
    logic             word_last;

    // byte_available is a level that may linger; only its rising edge counts.
    assign capture     = enable && byte_available && !avail_q;
    assign word_last   = (byte_cnt[SLOT_W-1:0] == SLOT_W'(WORD_BYTES - 1));
    assign sector_done = capture && (byte_cnt == CNT_W'(SECTOR_BYTES - 1));

    always_ff @(posedge clk25) begin
        if (reset) begin
            avail_q       <= 1'b0;
            byte_cnt      <= '0;
            partial       <= '0;
            word_out      <= '0;
            word_index    <= '0;
            word_valid    <= 1'b0;
            data_write_en <= 1'b0;
            song_write_en <= 1'b0;
        end else begin
            avail_q       <= byte_available;
            word_valid    <= capture && word_last;
            data_write_en <= capture && word_last && !song_phase;
            song_write_en <= capture && word_last && song_phase;

            if (clear_cnt)
                byte_cnt <= '0;
            else if (capture)
                byte_cnt <= byte_cnt + 1'b1;

            if (capture) begin
                case (byte_cnt[1:0])
                    2'd0: partial[23:16] <= din;
                    2'd1: partial[15:8]  <= din;
                    2'd2: partial[7:0]   <= din;
                    default: word_out    <= {partial, din};
                endcase
            end

            // The index advances the cycle after the strobe so it labels its word.
            if (clear_index)
                word_index <= '0;
            else if (word_valid)
                word_index <= word_index + 16'd1;
        end
    end

endmodule

// File: rtl/sd_load_sequencer.sv
// Loads metadata sectors after reset, then song sectors on request, driving
// sd_controller and streaming packed words to metadata memory or song buffer.
module sd_load_sequencer
    import cl_pkg::*;
#(
    parameter logic [31:0] DATA_ADR     = DATA_ADR_DEFAULT,
    parameter int          DATA_SECTORS = 4,
    parameter logic [31:0] SONG_ADR     = SONG_ADR_DEFAULT,
    parameter int          SONG_SECTORS = 16
) (
    input  logic        clk25,
    input  logic        reset,
    input  logic        song_req,
    input  logic        sd_ready,
    input  logic        sd_byte_available,
    input  logic [7:0]  sd_dout,
    output logic        sd_rd,
    output logic [31:0] sd_adr,
    output logic [31:0] word_out,
    output logic [15:0] word_index,
    output logic        data_write_en,
    output logic        song_write_en,
    output logic        data_loaded,
    output logic        song_loaded,
    output logic        busy
);

    localparam logic [6:0] DATA_LAST = 7'(DATA_SECTORS - 1);
    localparam logic [6:0] SONG_LAST = 7'(SONG_SECTORS - 1);

    seq_state_t  state, state_n;
    phase_t      phase, phase_n;
    logic [6:0]  sector_cnt, sector_cnt_n;
    logic [31:0] sd_adr_n;
    logic        sd_rd_n, data_loaded_n, song_loaded_n;
    logic        clear_cnt, clear_index, sector_done, last_sector;

    sd_byte_packer u_packer (
        .clk25          (clk25),
        .reset          (reset),
        .enable         (state == READ),
        .clear_cnt      (clear_cnt),
        .clear_index    (clear_index),
        .song_phase     (phase == PHASE_SONG),
        .byte_available (sd_byte_available),
        .din            (sd_dout),
        .word_out       (word_out),
        .word_index     (word_index),
        .data_write_en  (data_write_en),
        .song_write_en  (song_write_en),
        .sector_done    (sector_done)
    );

    // Read handshake: sd_rd rises only after sd_ready is seen high, and is held
    // until sd_ready is seen low (controller accepted); the sector ends when
    // the 512th byte arrives and sd_ready returns high.
    always_comb begin
        state_n       = state;
        phase_n       = phase;
        sector_cnt_n  = sector_cnt;
        sd_adr_n      = sd_adr;
        sd_rd_n       = sd_rd;
        data_loaded_n = data_loaded;
        song_loaded_n = song_loaded;
        clear_cnt     = 1'b0;
        clear_index   = 1'b0;
        last_sector   = (phase == PHASE_SONG) ? (sector_cnt == SONG_LAST)
                                              : (sector_cnt == DATA_LAST);
        case (state)
            WAIT_READY: begin
                if (sd_ready) begin
                    sd_rd_n = 1'b1;
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                if (!sd_ready) begin
                    sd_rd_n   = 1'b0;
                    clear_cnt = 1'b1;
                    state_n   = READ;
                end
            end
            READ: begin
                if (sector_done)
                    state_n = SECTOR_END;
            end
            SECTOR_END: begin
                if (sd_ready) begin
                    if (!last_sector) begin
                        sector_cnt_n = sector_cnt + 7'd1;
                        sd_adr_n     = sd_adr + 32'(SECTOR_BYTES);
                        state_n      = WAIT_READY;
                    end else if (phase == PHASE_DATA) begin
                        data_loaded_n = 1'b1;
                        state_n       = WAIT_SONG;
                    end else begin
                        song_loaded_n = 1'b1;
                        state_n       = DONE;
                    end
                end
            end
            WAIT_SONG: begin
                if (song_req) begin
                    phase_n      = PHASE_SONG;
                    sd_adr_n     = SONG_ADR;
                    sector_cnt_n = '0;
                    clear_index  = 1'b1;
                    state_n      = WAIT_READY;
                end
            end
            DONE: ;
            default: state_n = WAIT_READY;
        endcase
    end

    always_ff @(posedge clk25) begin
        if (reset) begin
            state       <= WAIT_READY;
            phase       <= PHASE_DATA;
            sector_cnt  <= '0;
            sd_adr      <= DATA_ADR;
            sd_rd       <= 1'b0;
            data_loaded <= 1'b0;
            song_loaded <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            phase       <= phase_n;
            sector_cnt  <= sector_cnt_n;
            sd_adr      <= sd_adr_n;
            sd_rd       <= sd_rd_n;
            data_loaded <= data_loaded_n;
            song_loaded <= song_loaded_n;
            busy        <= (state_n == ISSUE) || (state_n == READ) || (state_n == SECTOR_END);
        end
    end

endmodule

// File: tb/tb_sd_load_sequencer.sv
// Directed bench for sd_load_sequencer: a behavioural SD card serves bytes
// 0x00..0xFF repeating per sector while a monitor checks every strobe and read.
module tb_sd_load_sequencer;

    localparam logic [31:0] DATA_ADR = 32'h0000_0000;
    localparam logic [31:0] SONG_ADR = 32'h0001_0000;

    logic        clk25 = 1'b0;
    logic        reset;
    logic        song_req;
    logic        sd_ready;
    logic        sd_byte_available;
    logic [7:0]  sd_dout;
    logic        sd_rd;
    logic [31:0] sd_adr;
    logic [31:0] word_out;
    logic [15:0] word_index;
    logic        data_write_en;
    logic        song_write_en;
    logic        data_loaded;
    logic        song_loaded;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int hold_cycles = 1;
    int model_sector = 0;
    int model_bytes  = 0;
    int data_strobes = 0;
    int song_strobes = 0;
    int data_rises   = 0;
    int song_rises   = 0;
    logic        rd_q = 1'b0;
    logic [31:0] last_data_word = '0;

    sd_load_sequencer dut (
        .clk25             (clk25),
        .reset             (reset),
        .song_req          (song_req),
        .sd_ready          (sd_ready),
        .sd_byte_available (sd_byte_available),
        .sd_dout           (sd_dout),
        .sd_rd             (sd_rd),
        .sd_adr            (sd_adr),
        .word_out          (word_out),
        .word_index        (word_index),
        .data_write_en     (data_write_en),
        .song_write_en     (song_write_en),
        .data_loaded       (data_loaded),
        .song_loaded       (song_loaded),
        .busy              (busy)
    );

    always #20 clk25 = ~clk25;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Word k of any phase holds bytes 4k..4k+3 mod 256, since sectors restart at 0x00.
    function automatic logic [31:0] exp_word(input int idx);
        logic [7:0] b;
        b = 8'((idx * 4) % 256);
        return {b, b + 8'd1, b + 8'd2, b + 8'd3};
    endfunction

    task automatic check_reset_values();
        chk("rst_sd_rd", 32'(sd_rd), 0);
        chk("rst_sd_adr", sd_adr, DATA_ADR);
        chk("rst_word_out", word_out, 0);
        chk("rst_word_index", 32'(word_index), 0);
        chk("rst_data_we", 32'(data_write_en), 0);
        chk("rst_song_we", 32'(song_write_en), 0);
        chk("rst_data_loaded", 32'(data_loaded), 0);
        chk("rst_song_loaded", 32'(song_loaded), 0);
        chk("rst_busy", 32'(busy), 0);
    endtask

    task automatic apply_reset();
        @(negedge clk25);
        reset = 1'b1;
        repeat (3) @(negedge clk25);
        check_reset_values();
        reset = 1'b0;
    endtask

    task automatic wait_loaded(input bit song, input int budget, input string tag);
        int n = 0;
        while (!(song ? song_loaded : data_loaded) && n < budget) begin
            @(negedge clk25);
            n++;
        end
        chk(tag, 32'(song ? song_loaded : data_loaded), 1);
    endtask

    // Behavioural SD card: drops sd_ready on a read, serves 512 bytes, re-raises ready.
    initial begin : sd_model
        bit aborted;
        sd_ready = 1'b1;
        sd_byte_available = 1'b0;
        sd_dout = 8'h00;
        forever begin
            @(negedge clk25);
            if (reset) begin
                sd_ready = 1'b1;
                sd_byte_available = 1'b0;
                model_sector = 0;
                model_bytes = 0;
            end else if (sd_rd) begin
                aborted = 1'b0;
                sd_ready = 1'b0;
                model_bytes = 0;
                repeat (2) begin
                    @(negedge clk25);
                    if (reset) aborted = 1'b1;
                end
                for (int b = 0; b < 512 && !aborted; b++) begin
                    sd_dout = 8'(b);
                    sd_byte_available = 1'b1;
                    for (int h = 0; h < hold_cycles && !aborted; h++) begin
                        @(negedge clk25);
                        if (reset) aborted = 1'b1;
                    end
                    sd_byte_available = 1'b0;
                    if (!aborted) begin
                        model_bytes = b + 1;
                        @(negedge clk25);
                        if (reset) aborted = 1'b1;
                    end
                end
                if (aborted) begin
                    model_sector = 0;
                    model_bytes = 0;
                end else begin
                    model_sector++;
                end
                sd_ready = 1'b1;
            end
        end
    end

    // Monitor: data phase lasts until 512 data words; then the song phase begins.
    always begin : monitor
        @(posedge clk25);
        #1;
        if (reset) begin
            data_strobes = 0;
            song_strobes = 0;
            data_rises = 0;
            song_rises = 0;
            rd_q = 1'b0;
        end else begin
            if (sd_rd && !rd_q) begin
                if (data_strobes < 512) begin
                    chk("data_rd_adr", sd_adr, DATA_ADR + 32'(512 * data_rises));
                    chk("data_words_per_sector", 32'(data_strobes), 32'(128 * data_rises));
                    data_rises++;
                end else begin
                    chk("song_rd_adr", sd_adr, SONG_ADR + 32'(512 * song_rises));
                    chk("song_words_per_sector", 32'(song_strobes), 32'(128 * song_rises));
                    song_rises++;
                end
            end
            rd_q = sd_rd;
            if (data_write_en) begin
                chk("data_we_exclusive", 32'(song_write_en), 0);
                chk("data_we_in_data_phase", 32'(data_strobes < 512), 1);
                chk("data_word", word_out, exp_word(data_strobes));
                chk("data_index", 32'(word_index), 32'(data_strobes));
                last_data_word = word_out;
                data_strobes++;
            end
            if (song_write_en) begin
                chk("song_after_data", 32'(data_strobes), 512);
                chk("song_word", word_out, exp_word(song_strobes));
                chk("song_index", 32'(word_index), 32'(song_strobes));
                song_strobes++;
            end
        end
    end

    initial begin : directed
        int n;
        reset = 1'b1;
        song_req = 1'b0;
        hold_cycles = 1;

        // Full metadata load, idle, then song load.
        apply_reset();
        @(negedge clk25);
        chk("rd_one_cycle_after_ready", 32'(sd_rd), 1);
        chk("first_adr", sd_adr, DATA_ADR);
        chk("busy_in_issue", 32'(busy), 1);
        wait_loaded(1'b0, 8000, "data_loaded_timeout");
        chk("data_strobe_total", 32'(data_strobes), 512);
        chk("data_read_total", 32'(data_rises), 4);
        repeat (300) @(negedge clk25);
        chk("no_rd_without_song_req", 32'(data_rises + song_rises), 4);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_no_song_strobe", 32'(song_strobes), 0);
        chk("idle_song_loaded", 32'(song_loaded), 0);
        song_req = 1'b1;
        wait_loaded(1'b1, 20000, "song_loaded_timeout");
        chk("song_strobe_total", 32'(song_strobes), 2048);
        chk("song_read_total", 32'(song_rises), 16);
        chk("data_loaded_sticky", 32'(data_loaded), 1);
        repeat (100) @(negedge clk25);
        chk("done_ignores_song_req", 32'(song_rises), 16);
        chk("done_busy", 32'(busy), 0);
        song_req = 1'b0;

        // Byte flag held high for three cycles per byte.
        hold_cycles = 3;
        apply_reset();
        wait_loaded(1'b0, 10000, "held_flag_loaded_timeout");
        chk("held_flag_strobes", 32'(data_strobes), 512);
        chk("held_flag_reads", 32'(data_rises), 4);

        // Reset after 37 bytes of the third sector.
        hold_cycles = 1;
        apply_reset();
        n = 0;
        while (!(model_sector == 2 && model_bytes == 37) && n < 5000) begin
            @(posedge clk25);
            n++;
        end
        chk("mid_sector_reached", 32'(model_sector == 2 && model_bytes == 37), 1);
        @(negedge clk25);
        chk("pre_reset_strobes", 32'(data_strobes), 265);
        chk("pre_reset_adr", sd_adr, 32'h0000_0400);
        reset = 1'b1;
        @(negedge clk25);
        check_reset_values();
        @(negedge clk25);
        reset = 1'b0;
        @(negedge clk25);
        chk("reload_rd", 32'(sd_rd), 1);
        chk("reload_adr", sd_adr, DATA_ADR);
        n = 0;
        while (data_strobes < 1 && n < 2000) begin
            @(negedge clk25);
            n++;
        end
        chk("reload_first_word", last_data_word, 32'h0001_0203);

        // song_req held high from reset.
        song_req = 1'b1;
        apply_reset();
        wait_loaded(1'b1, 25000, "early_req_song_timeout");
        chk("early_req_data_strobes", 32'(data_strobes), 512);
        chk("early_req_song_strobes", 32'(song_strobes), 2048);
        chk("early_req_data_reads", 32'(data_rises), 4);
        chk("early_req_song_reads", 32'(song_rises), 16);
        song_req = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
